// File: rtl/compressor_4_2_tree_pipe_pkg.sv
// Shared constants and elaboration-time helpers for the 4:2 compressor tree.
package compressor_4_2_tree_pipe_pkg;

    localparam int MIN_OPS = 4;
    localparam int MAX_OPS = 16;

    // Ceiling log2 for positive integers, usable in constant expressions.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

    // Number of compressor levels: each level halves the vector count down to two.
    function automatic int tree_levels(input int num_ops);
        return clog2(num_ops) - 1;
    endfunction

    // Pipeline depth: one register per level plus the optional resolving adder.
    function automatic int tree_stages(input int num_ops, input int final_add);
        return tree_levels(num_ops) + final_add;
    endfunction

    // Only power-of-four-friendly operand counts map onto whole 4:2 groups.
    function automatic bit num_ops_legal(input int n);
        return (n == MIN_OPS) || (n == 8) || (n == MAX_OPS);
    endfunction

    // Index of the first word of level lvl's output inside the flattened
    // register array (levels are stored back to back, largest first).
    function automatic int level_base(input int num_ops, input int lvl);
        return num_ops - (num_ops >> lvl);
    endfunction

endpackage

// File: rtl/compressor_4_2_tree_pipe_if.sv
// Valid/ready operand and result bus of the compressor tree.
interface compressor_4_2_tree_pipe_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [NUM_OPS*WIDTH-1:0]   in_ops;
    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0]           out_sum;
    logic [WIDTH-1:0]           out_carry;

    modport master (
        output in_valid, in_ops, out_ready,
        input  in_ready, out_valid, out_sum, out_carry
    );

    modport slave (
        input  in_valid, in_ops, out_ready,
        output in_ready, out_valid, out_sum, out_carry
    );
endinterface

// File: rtl/compressor_4_2_tree_pipe_row.sv
// One WIDTH-wide row of 4:2 compressor cells with the intra-row ci/co chain.
// Reduces four vectors to an aligned sum/carry pair (modulo 2^WIDTH).
module compressor_4_2_row #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_c,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_carry
);
    // co and c of the MSB would land at weight 2^WIDTH, so they are never built.
    logic [WIDTH-2:0] w_co;
    logic [WIDTH-2:0] w_c;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        logic w_ci;
        logic w_s1;

        if (gi == 0) begin : g_lsb
            assign w_ci = 1'b0;
        end else begin : g_chain
            assign w_ci = w_co[gi-1];
        end

        assign w_s1      = i_a[gi] ^ i_b[gi] ^ i_c[gi];
        assign o_sum[gi] = w_s1 ^ i_d[gi] ^ w_ci;

        if (gi < WIDTH - 1) begin : g_carries
            assign w_co[gi] = (i_a[gi] & i_b[gi]) | (i_a[gi] & i_c[gi]) | (i_b[gi] & i_c[gi]);
            assign w_c[gi]  = (w_s1 & i_d[gi]) | (w_s1 & w_ci) | (i_d[gi] & w_ci);
        end
    end

    // c has weight 2^(i+1): shift it up so both outputs share bit alignment.
    assign o_carry = {w_c, 1'b0};

endmodule

// File: rtl/compressor_4_2_tree_pipe.sv
// Pipelined 4:2 carry-save reduction tree with valid/ready flow control.
// One register stage per level, optional final carry-propagate stage, and an
// enable chain that lets empty stages absorb data while the output is stalled.
module compressor_4_2_tree_pipe
    import compressor_4_2_tree_pipe_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int NUM_OPS   = 8,
    parameter int FINAL_ADD = 1
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    compressor_4_2_tree_pipe_if.slave     bus
);
    localparam int LEVELS  = tree_levels(NUM_OPS);
    localparam int S       = tree_stages(NUM_OPS, FINAL_ADD);
    localparam int N_WORDS = NUM_OPS - 2;

    if (!num_ops_legal(NUM_OPS)) begin : g_illegal_num_ops
        $error("compressor_4_2_tree_pipe: NUM_OPS must be 4, 8 or 16");
    end

    logic [S-1:0]       r_v;
    logic [S-1:0]       w_en;
    logic [S-1:0]       w_vin;
    logic [S-1:0]       w_ld;
    logic [WIDTH-1:0]   r_tree [N_WORDS];
    logic [WIDTH-1:0]   w_tree [N_WORDS];
    logic [N_WORDS-1:0] w_wload;

    // Enable chain written in closed form: a stage may advance if the output
    // is being consumed or any stage from here to the output is empty.
    for (genvar gi = 0; gi < S; gi++) begin : g_ctrl
        assign w_en[gi] = bus.out_ready || !(&r_v[S-1:gi]);
        if (gi == 0) begin : g_first
            assign w_vin[gi] = bus.in_valid;
        end else begin : g_next
            assign w_vin[gi] = r_v[gi-1];
        end
        assign w_ld[gi] = w_en[gi] && w_vin[gi];
    end

    assign bus.in_ready  = w_en[0];
    assign bus.out_valid = r_v[S-1];

    // Compressor levels: level gi reads its predecessor's registers (or the
    // input bus) and writes its own slice of the flattened word array.
    for (genvar gi = 0; gi < LEVELS; gi++) begin : g_lvl
        localparam int OUT_BASE = level_base(NUM_OPS, gi);
        localparam int IN_BASE  = (gi == 0) ? 0 : OUT_BASE - (NUM_OPS >> gi);
        localparam int GROUPS   = (NUM_OPS >> gi) / 4;

        for (genvar gj = 0; gj < GROUPS; gj++) begin : g_grp
            logic [WIDTH-1:0] w_op [4];
            logic [WIDTH-1:0] w_sum;
            logic [WIDTH-1:0] w_carry;

            for (genvar gk = 0; gk < 4; gk++) begin : g_src
                if (gi == 0) begin : g_bus
                    assign w_op[gk] = bus.in_ops[(4*gj+gk)*WIDTH +: WIDTH];
                end else begin : g_reg
                    assign w_op[gk] = r_tree[IN_BASE + 4*gj + gk];
                end
            end

            compressor_4_2_row #(.WIDTH(WIDTH)) u_row (
                .i_a     (w_op[0]),
                .i_b     (w_op[1]),
                .i_c     (w_op[2]),
                .i_d     (w_op[3]),
                .o_sum   (w_sum),
                .o_carry (w_carry)
            );

            assign w_tree[OUT_BASE + 2*gj]            = w_sum;
            assign w_tree[OUT_BASE + 2*gj + 1]        = w_carry;
            assign w_wload[OUT_BASE + 2*gj +: 2]      = {2{w_ld[gi]}};
        end
    end

    // Stage valid bits advance whenever their enable is high.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_v <= '0;
        end else begin
            for (int k = 0; k < S; k++) begin
                if (w_en[k]) begin
                    r_v[k] <= w_vin[k];
                end
            end
        end
    end

    // Level data registers load only alongside a valid token; bubbles keep stale data.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N_WORDS; i++) begin
                r_tree[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_WORDS; i++) begin
                if (w_wload[i]) begin
                    r_tree[i] <= w_tree[i];
                end
            end
        end
    end

    if (FINAL_ADD != 0) begin : g_final_add
        logic [WIDTH-1:0] r_sum;

        // Resolve the last carry-save pair into a plain binary result.
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                r_sum <= '0;
            end else if (w_ld[S-1]) begin
                r_sum <= r_tree[N_WORDS-2] + r_tree[N_WORDS-1];
            end
        end

        assign bus.out_sum   = r_sum;
        assign bus.out_carry = '0;
    end else begin : g_carry_save
        assign bus.out_sum   = r_tree[N_WORDS-2];
        assign bus.out_carry = r_tree[N_WORDS-1];
    end

endmodule

// File: tb/tb_compressor_4_2_tree_pipe.sv
// Bench for the compressor tree: a resolving 8-operand instance driven by
// directed and random sets, and a 16-operand carry-save instance on a random stream.
module tb_compressor_4_2_tree_pipe;

    localparam int W   = 16;
    localparam int S_A = 3;   // 8 ops: 2 levels + final add
    localparam int S_B = 3;   // 16 ops: 3 levels, carry-save out

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_err;
    int   pops_a;
    bit   lat_chk_a;
    bit   b_done;

    logic [W-1:0] qa_exp[$];
    int           qa_t[$];
    logic [W-1:0] qb_exp[$];
    int           qb_t[$];

    compressor_4_2_tree_pipe_if #(.WIDTH(W), .NUM_OPS(8))  ia ();
    compressor_4_2_tree_pipe_if #(.WIDTH(W), .NUM_OPS(16)) ib ();

    compressor_4_2_tree_pipe #(.WIDTH(W), .NUM_OPS(8), .FINAL_ADD(1)) u_dut_a (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (ia)
    );

    compressor_4_2_tree_pipe #(.WIDTH(W), .NUM_OPS(16), .FINAL_ADD(0)) u_dut_b (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: the modular sum of all operands, straight from the definition.
    function automatic logic [W-1:0] ref_sum(input logic [255:0] ops, input int n);
        logic [W-1:0] s;
        s = '0;
        for (int j = 0; j < n; j++) begin
            s = s + ops[j*W +: W];
        end
        return s;
    endfunction

    function automatic logic [127:0] rnd_ops8();
        logic [127:0] r;
        for (int j = 0; j < 4; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard for instance A: one line per completed transaction.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ia.out_valid && ia.out_ready) begin
                if (qa_exp.size() == 0) begin
                    check_eq("a_extra_out", {31'd0, ia.out_valid}, 32'd0);
                end else begin
                    logic [W-1:0] e;
                    int t;
                    e = qa_exp.pop_front();
                    t = qa_t.pop_front();
                    $display("A out: sum=%04h exp=%04h lat=%0d", ia.out_sum, e, cyc - t);
                    check_eq("a_sum", ia.out_sum, e);
                    check_eq("a_carry", ia.out_carry, 0);
                    if (lat_chk_a) check_eq("a_latency", cyc - t, S_A);
                    pops_a++;
                end
            end
            if (ia.in_valid && ia.in_ready) begin
                qa_exp.push_back(ref_sum({128'd0, ia.in_ops}, 8));
                qa_t.push_back(cyc);
            end
        end
    end

    // Scoreboard for instance B: sum+carry must resolve to the reference.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ib.out_valid && ib.out_ready) begin
                if (qb_exp.size() == 0) begin
                    check_eq("b_extra_out", {31'd0, ib.out_valid}, 32'd0);
                end else begin
                    logic [W-1:0] e;
                    logic [W-1:0] r;
                    int t;
                    e = qb_exp.pop_front();
                    t = qb_t.pop_front();
                    r = ib.out_sum + ib.out_carry;
                    $display("B out: s=%04h c=%04h sum=%04h exp=%04h lat=%0d",
                             ib.out_sum, ib.out_carry, r, e, cyc - t);
                    check_eq("b_sum", r, e);
                    check_eq("b_latency", cyc - t, S_B);
                end
            end
            if (ib.in_valid && ib.in_ready) begin
                qb_exp.push_back(ref_sum(ib.in_ops, 16));
                qb_t.push_back(cyc);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
    task automatic a_push(input logic [127:0] ops);
        int n;
        ia.in_valid = 1'b1;
        ia.in_ops   = ops;
        n = 0;
        @(negedge clk);
        while (!ia.in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        if (!ia.in_ready) check_eq("a_push_ready", {31'd0, ia.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        ia.in_valid = 1'b0;
    endtask

    task automatic a_drain();
        for (int i = 0; i < 60 && qa_exp.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("a_drain_empty", qa_exp.size(), 0);
    endtask

    // Random stream for the carry-save instance; output always ready.
    initial begin
        b_done       = 1'b0;
        ib.in_valid  = 1'b0;
        ib.in_ops    = '0;
        ib.out_ready = 1'b1;
        wait (rst_n === 1'b1);
        for (int i = 0; i < 250; i++) begin
            @(posedge clk);
            #1;
            ib.in_valid = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < 8; j++) ib.in_ops[j*32 +: 32] = $urandom;
        end
        @(posedge clk);
        #1;
        ib.in_valid = 1'b0;
        b_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] ops;
        n_chk = 0; n_err = 0; pops_a = 0; cyc = 0;
        lat_chk_a   = 1'b0;
        rst_n       = 1'b0;
        ia.in_valid = 1'b0;
        ia.in_ops   = '0;
        ia.out_ready = 1'b1;

        // Reset state
        #3;
        check_eq("rst_a_out_valid", {31'd0, ia.out_valid}, 0);
        check_eq("rst_a_out_sum",   ia.out_sum, 0);
        check_eq("rst_a_out_carry", ia.out_carry, 0);
        check_eq("rst_a_in_ready",  {31'd0, ia.in_ready}, 1);
        check_eq("rst_b_out_valid", {31'd0, ib.out_valid}, 0);
        check_eq("rst_b_out_sum",   ib.out_sum, 0);
        check_eq("rst_b_out_carry", ib.out_carry, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat_chk_a = 1'b1;

        // Directed: ops 1..8 -> 36
        for (int j = 0; j < 8; j++) ops[j*W +: W] = 16'(j + 1);
        a_push(ops);
        a_drain();

        // Wrap: all ones -> FFF8
        ops = '1;
        a_push(ops);
        // Signed: -3 + 5 -> 2
        ops = '0;
        ops[15:0]  = 16'hFFFD;
        ops[31:16] = 16'd5;
        a_push(ops);
        a_drain();

        // Random with gaps, free-flowing output
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end else begin
                a_push(rnd_ops8());
            end
        end
        a_drain();

        // Backpressure: three accepts fill the pipe, then pop+push together
        lat_chk_a = 1'b0;
        ia.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) a_push(rnd_ops8());
        ia.in_valid = 1'b1;
        ia.in_ops   = rnd_ops8();
        @(negedge clk);
        check_eq("bp_full_in_ready",   {31'd0, ia.in_ready}, 0);
        check_eq("bp_full_out_valid",  {31'd0, ia.out_valid}, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("bp_hold_in_ready",   {31'd0, ia.in_ready}, 0);
        @(posedge clk);
        #1;
        ia.out_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_popush_in_ready", {31'd0, ia.in_ready}, 1);
        @(posedge clk);
        #1;
        ia.in_valid = 1'b0;
        a_drain();

        // Bubble collapse: push, gap, push with output stalled
        ia.out_ready = 1'b0;
        a_push(rnd_ops8());
        @(negedge clk);
        check_eq("bub_gap_in_ready", {31'd0, ia.in_ready}, 1);
        @(posedge clk);
        #1;
        a_push(rnd_ops8());
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bub_in_ready", {31'd0, ia.in_ready}, 1);
            @(posedge clk);
            #1;
        end
        ia.in_valid = 1'b1;
        ia.in_ops   = rnd_ops8();
        @(negedge clk);
        check_eq("bub_third_in_ready", {31'd0, ia.in_ready}, 1);
        @(posedge clk);
        #1;
        ia.in_valid = 1'b0;
        @(negedge clk);
        check_eq("bub_full_in_ready",  {31'd0, ia.in_ready}, 0);
        @(posedge clk);
        #1;
        ia.out_ready = 1'b1;
        a_drain();

        // Reset with two sets in flight
        lat_chk_a = 1'b1;
        a_push(rnd_ops8());
        a_push(rnd_ops8());
        rst_n = 1'b0;
        qa_exp.delete(); qa_t.delete();
        qb_exp.delete(); qb_t.delete();
        #1;
        check_eq("midrst_out_valid", {31'd0, ia.out_valid}, 0);
        check_eq("midrst_in_ready",  {31'd0, ia.in_ready}, 1);
        check_eq("midrst_out_sum",   ia.out_sum, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        pops_a = 0;
        a_push(rnd_ops8());
        repeat (10) @(posedge clk);
        #1;
        check_eq("midrst_result_count", pops_a, 1);
        check_eq("midrst_queue_empty",  qa_exp.size(), 0);

        // Let the carry-save stream finish
        for (int i = 0; i < 2000 && !b_done; i++) @(posedge clk);
        check_eq("b_stream_done", {31'd0, b_done}, 1);
        repeat (10) @(posedge clk);
        #1;
        check_eq("b_drain_empty", qb_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/compressor_4_2_tree_pipe.md
# compressor_4_2_tree_pipe

Parametrised, pipelined carry-save reduction tree that sums NUM_OPS operands of WIDTH bits using rows of 4:2 compressors, with one register stage per tree level. An optional final carry-propagate adder resolves the result. It sits between the Booth partial-product generator and the final adder of the multiplier datapath, and adds a valid/ready handshake with backpressure and bubble collapsing.

## Interface
- WIDTH, 32, operand and result width in bits; all arithmetic is modulo 2^WIDTH.
- NUM_OPS, 8, number of operands; legal values are 4, 8 and 16.
- FINAL_ADD, 1, selects the output form: 1 registers sum+carry into out_sum; 0 emits the carry-save pair.
- sys_clk  in  1  single clock; all state changes on its rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_ops holds an operand set.
- in_ready  out  1  block accepts the set this cycle.
- in_ops  in  NUM_OPS*WIDTH  operand j is in_ops[j*WIDTH +: WIDTH].
- out_valid  out  1  out_sum/out_carry hold a result.
- out_ready  in  1  downstream consumes the result this cycle.
- out_sum  out  WIDTH  result (FINAL_ADD=1) or sum vector (FINAL_ADD=0).
- out_carry  out  WIDTH  carry vector, already aligned; constant 0 when FINAL_ADD=1.

## Operation
- LEVELS = log2(NUM_OPS) - 1; there are 1, 2 or 3 levels.
- Stage count S = LEVELS + FINAL_ADD.
- Each level takes 4k vectors and produces 2k vectors by grouping operands in fours, in index order.
- Per group, bit i uses one 4:2 cell with inputs i0..i3 = the bits of the 4 vectors and ci = co of bit i-1. Bit 0 has ci = 0. co of the MSB is dropped.
- Row outputs:
  - sum vector = d.
  - carry vector = c shifted left by 1, with bit 0 = 0 and c[WIDTH-1] dropped.
- Level output ordering: sum0, carry0, sum1, carry1, …
- Level l combinational logic feeds stage register l.
- FINAL_ADD stage: out_sum <= sum + carry, truncated to WIDTH bits.
- The result is sign-agnostic: two's-complement operands give the correct modular sum.
- Each stage k has a valid bit v_k and a data register.
- Enables: en_k = !v_k || en_{k+1}; en_{S+1} = out_ready; in_ready = en_1.
- When en_k is high, the stage loads: v_k <= (k==1 ? in_valid : v_{k-1}); data loads together with it.
- When en_k is low, the stage holds its data and valid.
- Bubbles collapse: an empty stage always accepts its upstream data, even while downstream is stalled.
- Data registers load only when the incoming valid is 1. Invalid stages keep their stale data; benches must not check data when valid is low.
- out_valid = v_S.
- Results leave in acceptance order. No data is dropped or duplicated.

## Timing
- On reset assertion, asynchronously: all v_k = 0 and all data registers = 0.
- Outputs after reset: out_valid = 0, out_sum = 0, out_carry = 0. in_ready = 1 (combinational from the cleared valids).
- Reset mid-operation discards every in-flight set. The first set after release is accepted normally.
- Latency: a set accepted at edge t is presented with out_valid = 1 immediately after edge t+S-1, i.e. S edges from acceptance to visibility.
  - Example: WIDTH=16, NUM_OPS=8, FINAL_ADD=1 gives S = 3.
- Throughput is one set per cycle while out_ready = 1.
- Capacity is S sets. With out_ready held low, in_ready falls once all S stages are valid.
- Simultaneous pop and push when full: allowed in the same cycle. in_ready = out_ready in that state.
- in_ready depends combinationally on out_ready through the enable chain. This path is accepted; there is no skid buffer.
- in_ops is sampled only on a handshake (in_valid && in_ready).

## Structure
- Shared package/header:
  - a clog2 function;
  - LEVELS and S derivation;
  - legal NUM_OPS check: any other value fails elaboration.
- Sub-module compressor_4_2_row:
  - one WIDTH-wide row of compressor_4_2 cells with the ci chain;
  - produces aligned sum/carry vectors;
  - instantiated by a generate loop per group per level.
- Top level contains:
  - stage registers;
  - valid/enable chain;
  - optional final adder.

## Test plan
- Directed sum: WIDTH=16, NUM_OPS=8, FINAL_ADD=1, ops = 1..8, single push. Required: out_sum = 36 exactly 3 edges after acceptance; out_carry = 0.
- Wrap: all 8 ops = 16'hFFFF. Required: out_sum = 16'hFFF8. With signed ops −3, 5, 0…0: out_sum = 2.
- Carry-save mode: FINAL_ADD=0, NUM_OPS=16, random ops. Required: (out_sum + out_carry) mod 2^16 equals the reference sum; latency is 3.
- Backpressure: hold out_ready = 0 and push 4 sets. Required:
  - in_ready goes low after 3 accepts;
  - release gives results in order with none lost;
  - a simultaneous pop and push when full is accepted.
- Bubble collapse: push at cycle 0, gap, push at cycle 2, with out_ready = 0. Required: both sets are packed into the last two stages and in_ready stays high.
- Reset mid-flight: assert sys_rst_n = 0 with 2 sets in flight. Required: out_valid = 0 immediately. After release, the next set's result is the only one produced.
